// File: rtl/adder_delay_pkg.sv
// Package: adder_delay_pkg
// Purpose: shared defaults and types for the adder delay model.
//   DEFAULT_WIDTH - operand/sum width used when the top is not overridden
//   DEFAULT_DELAY - propagation delay in clock cycles used by default
//   result_t      - {carry, sum} result word at the default width
package adder_delay_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DELAY = 12;

    typedef logic [DEFAULT_WIDTH:0] result_t;

endpackage : adder_delay_pkg

// File: rtl/adder_delay_model_delay_line.sv
// Module: delay_line
// Purpose: DEPTH-stage shift register with asynchronous active-low reset.
//   Stage 0 captures d_i on every rising edge; q_o is the last stage, so a
//   value captured at edge k is visible on q_o from edge k+DEPTH-1 onward.
// Ports:
//   clk_i  - rising-edge clock
//   rst_ni - asynchronous active-low reset, clears every stage
//   d_i    - WIDTH-bit input word
//   q_o    - WIDTH-bit delayed output word
module delay_line #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule : delay_line

// File: rtl/adder_delay_model.sv
// Module: adder_delay_model
// Purpose: cycle-based WIDTH-bit adder with carry-in/out offering three views
//   of the result: undelayed, transport-delayed (every change propagates) and
//   inertial-delayed (changes held for fewer than DELAY samples are dropped).
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   a, b   - WIDTH-bit operands
//   ci     - carry-in
//   sum/co     - combinational {co,sum} = a+b+ci
//   sum_t/co_t - transport-delayed result
//   sum_i/co_i - inertial-delayed result
//   pend_i     - 1 while the inertial sample differs from {co_i,sum_i}
module adder_delay_model
    import adder_delay_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DELAY = DEFAULT_DELAY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic [WIDTH-1:0] sum_t,
    output logic             co_t,
    output logic [WIDTH-1:0] sum_i,
    output logic             co_i,
    output logic             pend_i
);

    typedef logic [WIDTH:0] word_t;

    localparam int              CNT_W   = $clog2(DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    word_t raw;
    word_t tr_q;

    // Adder evaluated one bit wider so the carry falls out as the MSB.
    assign raw       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    assign {co, sum} = raw;

    // Transport path: plain DELAY-deep shift register of the raw result.
    delay_line #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DELAY)
    ) u_transport (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (raw),
        .q_o    (tr_q)
    );

    assign {co_t, sum_t} = tr_q;

    // Inertial path: smp follows raw, cnt counts how many consecutive samples
    // smp has been stable (saturating at DELAY).
    word_t            smp_q, smp_d;
    word_t            out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;

    always_comb begin
        smp_d = smp_q;
        cnt_d = cnt_q;
        out_d = out_q;

        if (raw != smp_q) begin
            smp_d = raw;
            cnt_d = CNT_ONE;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        // Publishing on the edge where the count reaches DELAY lines the
        // inertial output up with the transport output for long-held values,
        // and covers DELAY=1 where the loading edge already reaches the limit.
        if (cnt_d == CNT_MAX) begin
            out_d = smp_d;
        end

        pend_d = (smp_d != out_d);
    end

    // Reset leaves the counter saturated so the cleared sample counts as
    // already settled and nothing spurious is published after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q  <= '0;
            cnt_q  <= CNT_MAX;
            out_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            smp_q  <= smp_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            pend_q <= pend_d;
        end
    end

    assign {co_i, sum_i} = out_q;
    assign pend_i        = pend_q;

endmodule : adder_delay_model

// File: tb/tb_adder_delay_model.sv
// Testbench for adder_delay_model (WIDTH=4, DELAY=12).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// The reference keeps the history of raw sums captured at each rising edge
// since the last reset (earlier samples read as zero) and derives:
//   transport value = sample captured DELAY-1 edges ago
//   inertial value  = most recent sample that ends a run of DELAY equal samples
//   pending         = latest sample differs from the inertial value
module tb_adder_delay_model;

    localparam int WIDTH = 4;
    localparam int DELAY = 12;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a, b;
    logic             ci;
    logic [WIDTH-1:0] sum, sum_t, sum_i;
    logic             co, co_t, co_i, pend_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH:0] hist[$];

    adder_delay_model #(
        .WIDTH (WIDTH),
        .DELAY (DELAY)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .ci     (ci),
        .sum    (sum),
        .co     (co),
        .sum_t  (sum_t),
        .co_t   (co_t),
        .sum_i  (sum_i),
        .co_i   (co_i),
        .pend_i (pend_i)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (actual=running required=finished)");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [WIDTH:0] raw_in();
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    endfunction

    function automatic logic [WIDTH:0] hget(int j);
        if (j < 0) return '0;
        return hist[j];
    endfunction

    function automatic logic [WIDTH:0] model_transport();
        return hget(hist.size() - DELAY);
    endfunction

    function automatic logic [WIDTH:0] model_inertial();
        for (int m = hist.size() - 1; m >= -1; m--) begin
            logic ok;
            ok = 1'b1;
            for (int j = m - DELAY + 1; j <= m; j++) begin
                if (hget(j) !== hget(m)) ok = 1'b0;
            end
            if (ok) return hget(m);
        end
        return '0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a = '0; b = '0; ci = 1'b0;
        hist.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One rising edge: record the captured sample, then return the reference
    // values to compare against on the following falling edge.
    task automatic tick(output logic [WIDTH:0] e_c, output logic [WIDTH:0] e_t,
                        output logic [WIDTH:0] e_i, output logic e_p);
        @(posedge clk);
        hist.push_back(raw_in());
        @(negedge clk);
        e_c = raw_in();
        e_t = model_transport();
        e_i = model_inertial();
        e_p = (hist[hist.size()-1] !== e_i);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a = '0; b = '0; ci = 1'b0;
        hist.delete();
        #2;
        n_checks++; if ({co, sum} !== 5'h00) begin n_fail++; $display("FAIL reset_comb actual=%h required=00", {co, sum}); end
        n_checks++; if ({co_t, sum_t} !== 5'h00) begin n_fail++; $display("FAIL reset_transport actual=%h required=00", {co_t, sum_t}); end
        n_checks++; if ({co_i, sum_i} !== 5'h00) begin n_fail++; $display("FAIL reset_inertial actual=%h required=00", {co_i, sum_i}); end
        n_checks++; if (pend_i !== 1'b0) begin n_fail++; $display("FAIL reset_pend actual=%b required=0", pend_i); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_glitch_train();
        logic [WIDTH:0] e_c, e_t, e_i, s_t, s_i;
        logic e_p, s_p;
        do_reset();
        for (int e = 1; e <= 45; e++) begin
            if (e == 15) a = 4'hA;
            if (e == 17) b = 4'h3;
            if (e == 19) a = 4'h2;
            if (e == 21) a = 4'hF;
            if (e == 24) ci = 1'b1;
            tick(e_c, e_t, e_i, e_p);
            // Values stated for this train, indexed by capturing edge.
            s_t = (e < 26) ? 5'h00 : (e < 28) ? 5'h0A : (e < 30) ? 5'h0D :
                  (e < 32) ? 5'h05 : (e < 35) ? 5'h12 : 5'h13;
            s_i = (e < 35) ? 5'h00 : 5'h13;
            s_p = (e >= 15 && e <= 34);
            n_checks++; if ({co, sum} !== e_c) begin n_fail++; $display("FAIL glitch_comb e=%0d actual=%h required=%h", e, {co, sum}, e_c); end
            n_checks++; if ({co_t, sum_t} !== s_t) begin n_fail++; $display("FAIL glitch_transport e=%0d actual=%h required=%h", e, {co_t, sum_t}, s_t); end
            n_checks++; if ({co_i, sum_i} !== s_i) begin n_fail++; $display("FAIL glitch_inertial e=%0d actual=%h required=%h", e, {co_i, sum_i}, s_i); end
            n_checks++; if (pend_i !== s_p) begin n_fail++; $display("FAIL glitch_pend e=%0d actual=%b required=%b", e, pend_i, s_p); end
            n_checks++; if ({co_t, sum_t} !== e_t || {co_i, sum_i} !== e_i || pend_i !== e_p) begin
                n_fail++; $display("FAIL glitch_model e=%0d actual=%h/%h/%b required=%h/%h/%b", e, {co_t, sum_t}, {co_i, sum_i}, pend_i, e_t, e_i, e_p);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [WIDTH:0] e_c, e_t, e_i;
        logic e_p;
        a = 4'h7; b = 4'h0; ci = 1'b0;
        for (int e = 0; e < 16; e++) begin
            tick(e_c, e_t, e_i, e_p);
        end
        n_checks++; if ({co_t, sum_t} !== 5'h07 || {co_i, sum_i} !== 5'h07) begin
            n_fail++; $display("FAIL pre_async_reset actual=%h/%h required=07/07", {co_t, sum_t}, {co_i, sum_i});
        end
        #2;
        rst_n = 1'b0;
        hist.delete();
        #1;
        n_checks++; if ({co_t, sum_t} !== 5'h00) begin n_fail++; $display("FAIL async_reset_transport actual=%h required=00", {co_t, sum_t}); end
        n_checks++; if ({co_i, sum_i} !== 5'h00) begin n_fail++; $display("FAIL async_reset_inertial actual=%h required=00", {co_i, sum_i}); end
        n_checks++; if (pend_i !== 1'b0) begin n_fail++; $display("FAIL async_reset_pend actual=%b required=0", pend_i); end
        @(negedge clk);
        rst_n = 1'b1;
        a = '0;
        // After release nothing in flight may reappear.
        for (int e = 0; e < 14; e++) begin
            tick(e_c, e_t, e_i, e_p);
            n_checks++; if ({co_t, sum_t} !== 5'h00 || {co_i, sum_i} !== 5'h00 || pend_i !== 1'b0) begin
                n_fail++; $display("FAIL post_reset_quiet e=%0d actual=%h/%h/%b required=00/00/0", e, {co_t, sum_t}, {co_i, sum_i}, pend_i);
            end
        end
    endtask

    task automatic test_carry_extremes();
        logic [WIDTH:0] e_c, e_t, e_i;
        logic e_p;
        do_reset();
        a = 4'hF; b = 4'hF; ci = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick(e_c, e_t, e_i, e_p);
            n_checks++; if ({co_t, sum_t} !== e_t || {co_i, sum_i} !== e_i || pend_i !== e_p) begin
                n_fail++; $display("FAIL carry_model e=%0d actual=%h/%h/%b required=%h/%h/%b", e, {co_t, sum_t}, {co_i, sum_i}, pend_i, e_t, e_i, e_p);
            end
        end
        n_checks++; if (co !== 1'b1 || sum !== 4'hF) begin n_fail++; $display("FAIL carry_comb actual=%b/%h required=1/f", co, sum); end
        n_checks++; if ({co_t, sum_t} !== 5'h1F) begin n_fail++; $display("FAIL carry_transport actual=%h required=1f", {co_t, sum_t}); end
        n_checks++; if ({co_i, sum_i} !== 5'h1F) begin n_fail++; $display("FAIL carry_inertial actual=%h required=1f", {co_i, sum_i}); end
    endtask

    task automatic test_single_pulse();
        logic [WIDTH:0] e_c, e_t, e_i;
        logic e_p;
        int seen_t, first_t, seen_i;
        do_reset();
        seen_t = 0; first_t = -1; seen_i = 0;
        for (int e = 1; e <= 30; e++) begin
            a = (e == 5) ? 4'h5 : 4'h0;
            tick(e_c, e_t, e_i, e_p);
            if (sum_t == 4'h5) begin
                seen_t++;
                if (first_t < 0) first_t = e;
            end
            if (sum_i !== 4'h0) seen_i++;
        end
        n_checks++; if (seen_t !== 1) begin n_fail++; $display("FAIL pulse_transport_width actual=%0d required=1", seen_t); end
        n_checks++; if (first_t !== 16) begin n_fail++; $display("FAIL pulse_transport_edge actual=%0d required=16", first_t); end
        n_checks++; if (seen_i !== 0) begin n_fail++; $display("FAIL pulse_inertial_leak actual=%0d required=0", seen_i); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH:0] e_c, e_t, e_i, prev;
        logic e_p;
        do_reset();
        prev = '0;
        for (int e = 1; e <= 40; e++) begin
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            ci = 1'($urandom_range(0, 1));
            if (raw_in() == prev) ci = ~ci;
            prev = raw_in();
            tick(e_c, e_t, e_i, e_p);
            n_checks++; if ({co_i, sum_i} !== 5'h00) begin n_fail++; $display("FAIL b2b_inertial_hold e=%0d actual=%h required=00", e, {co_i, sum_i}); end
            n_checks++; if ({co_t, sum_t} !== e_t || pend_i !== e_p) begin
                n_fail++; $display("FAIL b2b_model e=%0d actual=%h/%b required=%h/%b", e, {co_t, sum_t}, pend_i, e_t, e_p);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH:0] e_c, e_t, e_i;
        logic e_p;
        int hold;
        do_reset();
        hold = 0;
        for (int e = 1; e <= 400; e++) begin
            if (hold == 0) begin
                a    = 4'($urandom_range(0, 15));
                b    = 4'($urandom_range(0, 15));
                ci   = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 16);
            end
            hold--;
            tick(e_c, e_t, e_i, e_p);
            n_checks++; if ({co, sum} !== e_c) begin n_fail++; $display("FAIL rand_comb e=%0d actual=%h required=%h", e, {co, sum}, e_c); end
            n_checks++; if ({co_t, sum_t} !== e_t) begin n_fail++; $display("FAIL rand_transport e=%0d actual=%h required=%h", e, {co_t, sum_t}, e_t); end
            n_checks++; if ({co_i, sum_i} !== e_i) begin n_fail++; $display("FAIL rand_inertial e=%0d actual=%h required=%h", e, {co_i, sum_i}, e_i); end
            n_checks++; if (pend_i !== e_p) begin n_fail++; $display("FAIL rand_pend e=%0d actual=%b required=%b", e, pend_i, e_p); end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_n = 1'b1;
        a = '0; b = '0; ci = 1'b0;
        test_reset();
        test_glitch_train();
        test_async_reset();
        test_carry_extremes();
        test_single_pulse();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_adder_delay_model
